key_debounce: RTL and testbench

//   Two-channel push-button conditioner placed directly upstream of led_controller.

---
 rtl/key_debounce.sv | 109 ++++++++++
 tb/tb_key_debounce.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Two-channel active-low push-button conditioner: 2-FF synchroniser followed by a
// per-channel stability counter FSM producing a clean level plus press/release strobes.
module key_debounce #(
    parameter int CNT_MAX = 1_000_000,
    parameter int CNT_W   = 20
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [1:0] key_in,
    output logic [1:0] key_out,
    output logic [1:0] key_press,
    output logic [1:0] key_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_HI  = 2'd0,
        S_WLO = 2'd1,
        S_LO  = 2'd2,
        S_WHI = 2'd3
    } state_t;

    logic [1:0] sync1_q;
    logic [1:0] sync2_q;

    // Reset to the released level so a held button is debounced from scratch afterwards.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             out_q;
        logic             press_q;
        logic             release_q;

        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                state_q   <= S_HI;
                cnt_q     <= '0;
                out_q     <= 1'b1;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state_q)
                    S_HI: begin
                        if (!sync2_q[gi]) begin
                            state_q <= S_WLO;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                    S_WLO: begin
                        if (sync2_q[gi]) begin
                            state_q <= S_HI;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= S_LO;
                            out_q   <= 1'b0;
                            press_q <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    S_LO: begin
                        if (sync2_q[gi]) begin
                            state_q <= S_WHI;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                    S_WHI: begin
                        if (!sync2_q[gi]) begin
                            state_q <= S_LO;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q   <= S_HI;
                            out_q     <= 1'b1;
                            release_q <= 1'b1;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= S_HI;
                        cnt_q   <= '0;
                        out_q   <= 1'b1;
                    end
                endcase
            end
        end

        assign key_out[gi]     = out_q;
        assign key_press[gi]   = press_q;
        assign key_release[gi] = release_q;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed + randomised bench for key_debounce; outputs compared every cycle against a
// run-length reference model (level accepted after CNT_MAX consecutive differing samples).
module tb_key_debounce;

    localparam int CNT_MAX = 8;
    localparam int CNT_W   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key_in = 2'b11;
    logic [1:0] key_out;
    logic [1:0] key_press;
    logic [1:0] key_release;

    int checks = 0;
    int errors = 0;

    logic [1:0] m_s1, m_s2, m_out, m_press, m_rel;
    int         m_run [2];

    key_debounce #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) dut (
        .sys_clk     (clk),
        .sys_rst     (rst),
        .key_in      (key_in),
        .key_out     (key_out),
        .key_press   (key_press),
        .key_release (key_release)
    );

    always #10 clk = ~clk;

    task automatic model_reset();
        m_s1 = 2'b11; m_s2 = 2'b11; m_out = 2'b11;
        m_press = 2'b00; m_rel = 2'b00;
        m_run[0] = 0; m_run[1] = 0;
    endtask

    task automatic model_edge();
        m_press = 2'b00;
        m_rel   = 2'b00;
        for (int c = 0; c < 2; c++) begin
            if (m_s2[c] !== m_out[c]) begin
                m_run[c]++;
                if (m_run[c] == CNT_MAX) begin
                    m_out[c] = m_s2[c];
                    if (m_out[c]) m_rel[c] = 1'b1;
                    else          m_press[c] = 1'b1;
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = key_in;
    endtask

    task automatic check2(string tag, logic [1:0] obs, logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check2("key_out", key_out, m_out);
        check2("key_press", key_press, m_press);
        check2("key_release", key_release, m_rel);
        check2("no_press_and_release", key_press & key_release, 2'b00);
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    // Counts edges until key_out matches want; stops at limit so a dead DUT still ends.
    task automatic wait_out(logic [1:0] mask, logic [1:0] want, int limit, output int edges);
        edges = 0;
        while (((key_out & mask) !== (want & mask)) && edges < limit) begin
            step();
            edges++;
        end
    endtask

    int e;
    int n;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        // 1: reset held 200 ns with buttons released
        run(10);
        check2("reset_key_out", key_out, 2'b11);
        @(negedge clk) rst = 1'b0;
        run(5);

        // 2: channel 0 pressed and held
        key_in = 2'b10;
        step();
        wait_out(2'b01, 2'b00, 20, e);
        check_int("press0_latency", e, 9);
        check2("press0_strobe", key_press, 2'b01);
        check2("press0_ch1_level", key_out, 2'b10);
        run(10);

        // 3: channel 1 bounce then settle low
        key_in = 2'b00; run(5);
        key_in = 2'b10; run(2);
        key_in = 2'b00; run(5);
        key_in = 2'b10; run(3);
        check2("bounce_no_change", key_out, 2'b10);
        key_in = 2'b00;
        step();
        wait_out(2'b10, 2'b00, 20, e);
        check_int("press1_latency", e, 9);
        check2("press1_strobe", key_press, 2'b10);
        run(3);

        // 4: both released together
        key_in = 2'b11;
        step();
        wait_out(2'b11, 2'b11, 20, e);
        check_int("release_both_latency", e, 9);
        check2("release_both_strobe", key_release, 2'b11);
        run(5);

        // 5: reset while channel 0 is mid-count
        key_in = 2'b10;
        step();
        n = 0;
        while (m_run[0] != 5 && n < 20) begin
            step();
            n++;
        end
        check_int("mid_count_reached", m_run[0], 5);
        #3 rst = 1'b1;
        model_reset();
        #2;
        check2("reset_async_out", key_out, 2'b11);
        check2("reset_async_press", key_press, 2'b00);
        check2("reset_async_release", key_release, 2'b00);
        run(2);
        @(negedge clk) rst = 1'b0;
        step();
        wait_out(2'b01, 2'b00, 20, e);
        check_int("post_reset_latency", e, 9);
        check2("post_reset_press", key_press, 2'b01);
        key_in = 2'b11;
        run(15);

        // 6: long holds, then randomised bouncy traffic
        key_in = 2'b10; run(500);
        key_in = 2'b01; run(500);
        key_in = 2'b00; run(500);
        for (int i = 0; i < 300; i++) begin
            key_in = 2'($urandom_range(0, 3));
            run($urandom_range(1, 14));
        end
        key_in = 2'b11;
        run(20);
        check2("final_released", key_out, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
